// File: rtl/arith_host_pkg.sv
// -----------------------------------------------------------------------------
// arith_host_pkg
// Shared definitions for the arithmetic host and its downstream blocks.
//   ARITH_DATA_W    : width of the host result word
//   COLLECTOR_DEPTH : default number of entries in the result collector FIFO
//   MULT_SEED       : multiplier seed constant used by the host datapath
//   ptr_width()     : pointer width needed to index a power-of-two depth
// -----------------------------------------------------------------------------
package arith_host_pkg;

    localparam int ARITH_DATA_W    = 16;
    localparam int COLLECTOR_DEPTH = 8;
    localparam logic [31:0] MULT_SEED = 32'h9E37_79B9;

    // Pointer width for a storage array of the given depth (never below 1 bit).
    function automatic int ptr_width(input int depth);
        if (depth < 2) begin
            return 1;
        end else begin
            return $clog2(depth);
        end
    endfunction

endpackage

// File: rtl/result_fifo_core.sv
// -----------------------------------------------------------------------------
// result_fifo_core
// First-word-fall-through storage for the result collector. Holds the storage
// array, read/write pointers and occupancy, and qualifies push/pop.
// Ports:
//   clk, rst          : clock, asynchronous active-high reset
//   wr_valid, wr_data : incoming word (cannot be back-pressured)
//   rd_ready          : consumer accepts the head word
//   rd_data           : raw head entry (not zeroed when empty)
//   level             : occupancy 0..DEPTH
//   full, empty       : occupancy flags
//   push, pop         : qualified write / read strobes for this cycle
// -----------------------------------------------------------------------------
module result_fifo_core
    import arith_host_pkg::*;
#(
    parameter int DATA_W = ARITH_DATA_W,
    parameter int DEPTH  = COLLECTOR_DEPTH
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_valid,
    input  logic [DATA_W-1:0]        wr_data,
    input  logic                     rd_ready,
    output logic [DATA_W-1:0]        rd_data,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     full,
    output logic                     empty,
    output logic                     push,
    output logic                     pop
);

    localparam int PTR_W = ptr_width(DEPTH);
    localparam int LVL_W = $clog2(DEPTH) + 1;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]  level_q, level_d;
    logic              full_s, empty_s, push_s, pop_s;

    // Occupancy flags and push/pop qualification. A full FIFO still accepts a
    // word when the head leaves in the same cycle; an empty FIFO never pops.
    always_comb begin
        empty_s = (level_q == LVL_W'(0));
        full_s  = (level_q == LVL_W'(DEPTH));
        pop_s   = (!empty_s) && rd_ready;
        push_s  = wr_valid && ((!full_s) || pop_s);
    end

    // Next-state for pointers, occupancy and storage. Pointers wrap naturally.
    always_comb begin
        mem_d = mem_q;
        if (push_s) begin
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
            mem_d[wr_ptr_q] = wr_data;
        end else begin
            wr_ptr_d = wr_ptr_q;
        end

        if (pop_s) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end

        case ({push_s, pop_s})
            2'b10:   level_d = level_q + LVL_W'(1);
            2'b01:   level_d = level_q - LVL_W'(1);
            default: level_d = level_q;
        endcase
    end

    // Control state: pointers and occupancy, flushed by reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= {PTR_W{1'b0}};
            rd_ptr_q <= {PTR_W{1'b0}};
            level_q  <= {LVL_W{1'b0}};
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    // Storage array; contents are don't-care after reset since level gates them.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign rd_data = mem_q[rd_ptr_q];
    assign level   = level_q;
    assign full    = full_s;
    assign empty   = empty_s;
    assign push    = push_s;
    assign pop     = pop_s;

endmodule

// File: rtl/arith_result_collector.sv
// -----------------------------------------------------------------------------
// arith_result_collector
// Captures the non-stallable result stream of the arithmetic host into a FWFT
// FIFO and presents it to a consumer over ready/valid. Words arriving while
// the FIFO is full and not draining are dropped, counted and flagged. A
// running 32-bit sum of accepted words serves as an integrity signature.
// Ports:
//   clk, rst             : clock, asynchronous active-high reset
//   in_valid, in_data    : host result stream (no backpressure)
//   out_valid, out_ready : consumer handshake; out_data is 0 when empty
//   level                : FIFO occupancy 0..DEPTH
//   overflow, clr_ovf    : sticky drop flag and its synchronous clear
//   drop_count           : saturating dropped-word counter (reset only)
//   accum, accum_clr     : running sum of accepted words and its clear
// -----------------------------------------------------------------------------
module arith_result_collector
    import arith_host_pkg::*;
#(
    parameter int DATA_W = ARITH_DATA_W,
    parameter int DEPTH  = COLLECTOR_DEPTH,
    parameter int CNT_W  = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    input  logic [DATA_W-1:0]        in_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [DATA_W-1:0]        out_data,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     overflow,
    input  logic                     clr_ovf,
    output logic [CNT_W-1:0]         drop_count,
    output logic [31:0]              accum,
    input  logic                     accum_clr
);

    logic [DATA_W-1:0] head_s;
    logic              full_s, empty_s, push_s, pop_s, drop_s;
    logic [31:0]       in_ext_s;

    logic              overflow_q, overflow_d;
    logic [CNT_W-1:0]  drop_count_q, drop_count_d;
    logic [31:0]       accum_q, accum_d;

    result_fifo_core #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .wr_valid (in_valid),
        .wr_data  (in_data),
        .rd_ready (out_ready),
        .rd_data  (head_s),
        .level    (level),
        .full     (full_s),
        .empty    (empty_s),
        .push     (push_s),
        .pop      (pop_s)
    );

    // A word is lost only when it arrives while full and nothing drains.
    always_comb begin
        drop_s   = in_valid && full_s && (!pop_s);
        in_ext_s = 32'(in_data);
    end

    // Sticky overflow (a drop beats a clear), saturating drop counter, and
    // signature accumulator (clear with push restarts from the new word).
    always_comb begin
        if (drop_s) begin
            overflow_d = 1'b1;
        end else if (clr_ovf) begin
            overflow_d = 1'b0;
        end else begin
            overflow_d = overflow_q;
        end

        if (drop_s && (drop_count_q != {CNT_W{1'b1}})) begin
            drop_count_d = drop_count_q + CNT_W'(1);
        end else begin
            drop_count_d = drop_count_q;
        end

        if (accum_clr) begin
            if (push_s) begin
                accum_d = in_ext_s;
            end else begin
                accum_d = 32'h0000_0000;
            end
        end else if (push_s) begin
            accum_d = accum_q + in_ext_s;
        end else begin
            accum_d = accum_q;
        end
    end

    // Status and signature registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow_q   <= 1'b0;
            drop_count_q <= {CNT_W{1'b0}};
            accum_q      <= 32'h0000_0000;
        end else begin
            overflow_q   <= overflow_d;
            drop_count_q <= drop_count_d;
            accum_q      <= accum_d;
        end
    end

    // Head word is forced to zero when nothing is buffered so stale storage
    // never leaks to the consumer.
    always_comb begin
        if (empty_s) begin
            out_data = {DATA_W{1'b0}};
        end else begin
            out_data = head_s;
        end
    end

    assign out_valid  = !empty_s;
    assign overflow   = overflow_q;
    assign drop_count = drop_count_q;
    assign accum      = accum_q;

endmodule

// File: tb/tb_arith_result_collector.sv
module tb_arith_result_collector;

    localparam int DATA_W = 16;
    localparam int DEPTH  = 8;
    localparam int CNT_W  = 16;

    logic              clk;
    logic              rst;
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic [3:0]        level;
    logic              overflow;
    logic              clr_ovf;
    logic [CNT_W-1:0]  drop_count;
    logic [31:0]       accum;
    logic              accum_clr;

    int total = 0;
    int bad   = 0;

    // Reference model: a plain queue plus scalar status
    logic [DATA_W-1:0] mq[$];
    logic [31:0]       m_accum;
    logic              m_ovf;
    logic [CNT_W-1:0]  m_drops;

    logic [DATA_W-1:0] fill_words [DEPTH];

    arith_result_collector #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .CNT_W  (CNT_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .level      (level),
        .overflow   (overflow),
        .clr_ovf    (clr_ovf),
        .drop_count (drop_count),
        .accum      (accum),
        .accum_clr  (accum_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
    end

    task automatic model_reset();
        mq.delete();
        m_accum = 32'd0;
        m_ovf   = 1'b0;
        m_drops = '0;
    endtask

    // Advance the model by one clock using the currently driven inputs, then
    // clock the DUT and settle 1 ns past the edge.
    task automatic cycle();
        bit pop_m, push_m, drop_m;
        pop_m  = (mq.size() > 0) && out_ready;
        push_m = in_valid && ((mq.size() < DEPTH) || pop_m);
        drop_m = in_valid && !push_m;
        if (accum_clr) m_accum = push_m ? {16'd0, in_data} : 32'd0;
        else if (push_m) m_accum = m_accum + {16'd0, in_data};
        if (drop_m) m_ovf = 1'b1;
        else if (clr_ovf) m_ovf = 1'b0;
        if (drop_m && m_drops != 16'hFFFF) m_drops = m_drops + 16'd1;
        if (pop_m) void'(mq.pop_front());
        if (push_m) mq.push_back(in_data);
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        in_valid  = 1'b0;
        in_data   = 16'h0000;
        out_ready = 1'b0;
        clr_ovf   = 1'b0;
        accum_clr = 1'b0;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 10; i++) begin
            total++;
            if (out_valid !== 1'b0 || out_data !== 16'h0000 || level !== 4'd0 ||
                accum !== 32'd0 || overflow !== 1'b0 || drop_count !== 16'd0) begin
                bad++;
                $display("FAIL reset_idle cyc=%0d got v=%b d=%h lvl=%0d acc=%h ovf=%b drp=%0d exp all zero",
                         i, out_valid, out_data, level, accum, overflow, drop_count);
            end
            cycle();
        end
    endtask

    task automatic test_basic();
        logic [15:0] words [3];
        words[0] = 16'h0003; words[1] = 16'hFFFF; words[2] = 16'h1234;
        in_valid = 1'b1; in_data = words[0];
        cycle();
        total++;
        if (out_valid !== 1'b1 || out_data !== 16'h0003 || level !== 4'd1) begin
            bad++;
            $display("FAIL basic_first got v=%b d=%h lvl=%0d exp v=1 d=0003 lvl=1", out_valid, out_data, level);
        end
        in_data = words[1]; cycle();
        in_data = words[2]; cycle();
        in_valid = 1'b0;
        total++;
        if (level !== 4'd3 || accum !== 32'h0001_1236 || out_data !== 16'h0003) begin
            bad++;
            $display("FAIL basic_fill got lvl=%0d acc=%h d=%h exp lvl=3 acc=00011236 d=0003", level, accum, out_data);
        end
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            total++;
            if (out_valid !== 1'b1 || out_data !== words[i]) begin
                bad++;
                $display("FAIL basic_drain%0d got v=%b d=%h exp v=1 d=%h", i, out_valid, out_data, words[i]);
            end
            cycle();
        end
        out_ready = 1'b0;
        total++;
        if (level !== 4'd0 || out_valid !== 1'b0 || out_data !== 16'h0000) begin
            bad++;
            $display("FAIL basic_empty got lvl=%0d v=%b d=%h exp 0 0 0000", level, out_valid, out_data);
        end
    endtask

    task automatic test_overflow();
        logic [31:0] sum;
        accum_clr = 1'b1; clr_ovf = 1'b1; cycle();
        accum_clr = 1'b0; clr_ovf = 1'b0;
        sum = 32'd0;
        in_valid = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            fill_words[i] = 16'($urandom);
            sum = sum + {16'd0, fill_words[i]};
            in_data = fill_words[i];
            cycle();
        end
        for (int i = 0; i < 2; i++) begin
            in_data = 16'($urandom);
            cycle();
        end
        in_valid = 1'b0;
        total++;
        if (level !== 4'd8 || overflow !== 1'b1 || drop_count !== 16'd2) begin
            bad++;
            $display("FAIL ovf_status got lvl=%0d ovf=%b drp=%0d exp lvl=8 ovf=1 drp=2", level, overflow, drop_count);
        end
        total++;
        if (accum !== sum || accum !== m_accum) begin
            bad++;
            $display("FAIL ovf_accum got=%h exp=%h", accum, sum);
        end
        total++;
        if (out_data !== fill_words[0]) begin
            bad++;
            $display("FAIL ovf_head got=%h exp=%h", out_data, fill_words[0]);
        end
    endtask

    task automatic test_full_passthrough();
        clr_ovf = 1'b1; cycle(); clr_ovf = 1'b0;
        in_valid = 1'b1; out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            total++;
            if (out_data !== fill_words[i] || out_data !== mq[0]) begin
                bad++;
                $display("FAIL pass_order%0d got=%h exp=%h", i, out_data, fill_words[i]);
            end
            in_data = 16'($urandom);
            cycle();
            total++;
            if (level !== 4'd8 || overflow !== 1'b0 || drop_count !== 16'd2) begin
                bad++;
                $display("FAIL pass_status%0d got lvl=%0d ovf=%b drp=%0d exp 8 0 2", i, level, overflow, drop_count);
            end
        end
        in_valid = 1'b0; out_ready = 1'b0;
        // Remaining original words still come first, then the pass-through ones
        total++;
        if (out_data !== fill_words[5]) begin
            bad++;
            $display("FAIL pass_head got=%h exp=%h", out_data, fill_words[5]);
        end
    endtask

    task automatic test_simultaneous();
        int guard;
        clr_ovf = 1'b1; in_valid = 1'b1; in_data = 16'hDEAD; cycle();
        clr_ovf = 1'b0; in_valid = 1'b0;
        total++;
        if (overflow !== 1'b1 || drop_count !== 16'd3) begin
            bad++;
            $display("FAIL simul_clr_drop got ovf=%b drp=%0d exp ovf=1 drp=3", overflow, drop_count);
        end
        clr_ovf = 1'b1; cycle(); clr_ovf = 1'b0;
        total++;
        if (overflow !== 1'b0) begin
            bad++;
            $display("FAIL simul_clr got ovf=%b exp 0", overflow);
        end
        out_ready = 1'b1;
        guard = 0;
        while (out_valid === 1'b1 && guard < 20) begin
            total++;
            if (out_data !== mq[0]) begin
                bad++;
                $display("FAIL simul_drain got=%h exp=%h", out_data, mq[0]);
            end
            cycle();
            guard++;
        end
        out_ready = 1'b0;
        total++;
        if (level !== 4'd0 || guard != 8) begin
            bad++;
            $display("FAIL simul_drain_len got lvl=%0d pops=%0d exp lvl=0 pops=8", level, guard);
        end
        accum_clr = 1'b1; in_valid = 1'b1; in_data = 16'h00AA; cycle();
        accum_clr = 1'b0; in_valid = 1'b0;
        total++;
        if (accum !== 32'h0000_00AA) begin
            bad++;
            $display("FAIL simul_accum_clr got=%h exp=000000aa", accum);
        end
    endtask

    task automatic test_reset_mid_drain();
        in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_data = 16'($urandom);
            cycle();
        end
        in_valid = 1'b0;
        total++;
        if (level !== 4'd5) begin
            bad++;
            $display("FAIL rstmid_level got=%0d exp=5", level);
        end
        out_ready = 1'b1; cycle();
        #2;
        rst = 1'b1;
        #1;
        total++;
        if (out_valid !== 1'b0 || level !== 4'd0 || out_data !== 16'h0000) begin
            bad++;
            $display("FAIL rstmid_async got v=%b lvl=%0d d=%h exp 0 0 0000", out_valid, level, out_data);
        end
        idle_inputs();
        model_reset();
        @(posedge clk); @(posedge clk);
        #1;
        rst = 1'b0;
        cycle();
        total++;
        if (level !== 4'd0 || drop_count !== 16'd0 || out_valid !== 1'b0 || accum !== 32'd0) begin
            bad++;
            $display("FAIL rstmid_after got lvl=%0d drp=%0d v=%b acc=%h exp all zero", level, drop_count, out_valid, accum);
        end
    endtask

    task automatic test_random();
        logic [15:0] exp_d;
        for (int i = 0; i < 400; i++) begin
            in_valid  = ($urandom_range(0, 99) < 70);
            in_data   = 16'($urandom);
            out_ready = ($urandom_range(0, 99) < 45);
            clr_ovf   = ($urandom_range(0, 99) < 5);
            accum_clr = ($urandom_range(0, 99) < 4);
            exp_d = (mq.size() > 0) ? mq[0] : 16'h0000;
            total++;
            if (out_valid !== (mq.size() > 0) || out_data !== exp_d || level !== 4'(mq.size())) begin
                bad++;
                $display("FAIL rand_fifo cyc=%0d got v=%b d=%h lvl=%0d exp v=%b d=%h lvl=%0d",
                         i, out_valid, out_data, level, (mq.size() > 0), exp_d, mq.size());
            end
            total++;
            if (overflow !== m_ovf || drop_count !== m_drops || accum !== m_accum) begin
                bad++;
                $display("FAIL rand_status cyc=%0d got ovf=%b drp=%0d acc=%h exp ovf=%b drp=%0d acc=%h",
                         i, overflow, drop_count, accum, m_ovf, m_drops, m_accum);
            end
            cycle();
        end
        idle_inputs();
    endtask

    initial begin
        rst = 1'b1;
        idle_inputs();
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        test_reset();
        test_basic();
        test_overflow();
        test_full_passthrough();
        test_simultaneous();
        test_reset_mid_drain();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/arith_result_collector.md
Name: arith_result_collector

Overview:
- Sits directly downstream of the arithmetic host and captures its result_out/valid_out stream.
- The host cannot be stalled, so this block absorbs results into a first-word-fall-through FIFO. It presents them to a consumer over a ready/valid handshake.
- Overruns are counted and flagged, never silent.
- A running 32-bit sum of accepted results gives the integrity-checking logic a cheap signature.

Parameters:
- DATA_W, 16, result word width; matches the host output width.
- DEPTH, 8, FIFO entries; power of two, minimum 2.
- CNT_W, 16, width of the drop counter.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  reset, asynchronous, active-high.
- in_valid  in  1  result valid from the host; no backpressure.
- in_data  in  DATA_W  result word from the host.
- out_valid  out  1  FIFO non-empty.
- out_ready  in  1  consumer accepts the head word.
- out_data  out  DATA_W  head word; 0 when empty.
- level  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
- overflow  out  1  sticky; set on any dropped word.
- clr_ovf  in  1  synchronous clear of overflow.
- drop_count  out  CNT_W  saturating count of dropped words.
- accum  out  32  running sum of accepted words mod 2^32.
- accum_clr  in  1  synchronous clear of accum.

Behaviour:
- Reset (async, immediate):
  - rd/wr pointers 0, level 0, out_valid 0, out_data 0.
  - overflow 0, drop_count 0, accum 0.
  - FIFO storage contents need not be reset.
- push = in_valid && (level<DEPTH || pop).
- pop = out_valid && out_ready.
- Pointers are $clog2(DEPTH) bits and wrap naturally from DEPTH-1 to 0.
- level update: +1 on push only, -1 on pop only, unchanged on both or neither.
- FWFT timing:
  - A word written at edge N appears on out_data with out_valid=1 after edge N.
  - Write-to-output latency is 1 cycle.
  - There is no same-cycle bypass when empty.
- Empty + in_valid + out_ready: word is written; out_valid stays 0 that cycle; no pop occurs.
- Full + in_valid + out_ready: simultaneous push and pop; level stays DEPTH; no drop.
- Full + in_valid + !out_ready: word is discarded.
  - overflow <= 1.
  - drop_count increments, saturating at all-ones.
  - accum is not updated.
- clr_ovf: overflow <= 0, unless a drop occurs the same cycle (set wins). drop_count is never cleared except by rst.
- accum:
  - On push, accum <= accum + zero-extended in_data.
  - accum_clr alone: accum <= 0.
  - accum_clr with push: accum <= zero-extended in_data.
- out_valid/out_ready handshake:
  - out_data is stable while out_valid=1 and out_ready=0.
  - out_valid never deasserts without a pop.
- in_data is ignored when in_valid=0.
- Reset mid-stream flushes all buffered words. The consumer sees out_valid drop asynchronously.

Decomposition:
- Shared package arith_host_pkg holds:
  - ARITH_DATA_W=16;
  - default collector depth (8);
  - a ptr_width function (clog2);
  - the MULT_SEED constant already used by the host.
- One sub-module, result_fifo_core, holds the storage array, pointers, level, and push/pop qualification. It exports full/empty.
- The top level adds the overflow/drop, accum, and output-zeroing logic.

Test Plan:
- Reset then idle: out_valid=0, out_data=0, level=0, accum=0, overflow=0 for 10 cycles.
- Push 16'h0003, 16'hFFFF, 16'h1234 on consecutive cycles with out_ready=0:
  - level=3, out_data=16'h0003 one cycle after the first push;
  - accum=32'h0001_1236.
  - Then out_ready=1: words drain in order in 3 cycles; level returns to 0.
- Fill 8 words with out_ready=0, then push 2 more:
  - level=8, overflow=1, drop_count=2, accum excludes the 2 dropped words.
  - Head is still the first word.
- Full FIFO, in_valid=1 and out_ready=1 for 5 cycles: level stays 8, overflow stays 0, output order is preserved across pointer wrap.
- Simultaneous events:
  - clr_ovf with a drop in the same cycle leaves overflow=1.
  - accum_clr with a push of 16'h00AA gives accum=32'h0000_00AA.
- Assert rst mid-drain with 5 words buffered: out_valid falls immediately; after release level=0 and drop_count=0.
